// File: rtl/uart_rx_controller.sv
// uart_rx_controller: 8N1 UART receive sequencer with a one-entry output register
//
// Samples RXD at bit centres using an internal baud counter. It holds each received
// byte until the consumer acknowledges it, and reports framing and overrun errors.
//
// Parameters:
//   SCYCLE    system clock frequency in Hz
//   BAUDRATE  line rate in baud; BDR = SCYCLE/BAUDRATE cycles per bit
//
// Ports:
//   i_clk        system clock, rising edge
//   i_reset      synchronous active-high reset
//   i_rxd        asynchronous serial input, idles high
//   i_rx_ack     consumer acknowledge, clears o_rx_valid
//   o_rx_data    last received byte, LSB = first data bit
//   o_rx_valid   o_rx_data holds an unacknowledged byte
//   o_frame_err  one-cycle pulse: stop bit sampled low
//   o_overrun    one-cycle pulse: unacknowledged byte overwritten
//   o_busy       receiver is inside a frame (not IDLE)
module uart_rx_controller #(
    parameter int SCYCLE   = 50_000_000,
    parameter int BAUDRATE = 9600
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic       i_rxd,
    input  logic       i_rx_ack,
    output logic [7:0] o_rx_data,
    output logic       o_rx_valid,
    output logic       o_frame_err,
    output logic       o_overrun,
    output logic       o_busy
);
    localparam int BDR  = SCYCLE / BAUDRATE;
    localparam int HALF = BDR / 2;
    localparam int CW   = $clog2(BDR + 1);

    typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAITHI} state_t;

    state_t        r_state;
    logic          r_sync1;
    logic          r_sync2;
    logic [CW-1:0] r_cnt;
    logic [2:0]    r_bit;
    logic [7:0]    r_shift;

    logic w_rs;
    logic w_bit_end;
    logic w_half_end;

    assign w_rs       = r_sync2;
    assign w_bit_end  = r_cnt == CW'(BDR - 1);
    assign w_half_end = r_cnt == CW'(HALF - 1);

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state     <= IDLE;
            r_sync1     <= 1'b1;
            r_sync2     <= 1'b1;
            r_cnt       <= '0;
            r_bit       <= '0;
            r_shift     <= '0;
            o_rx_data   <= '0;
            o_rx_valid  <= 1'b0;
            o_frame_err <= 1'b0;
            o_overrun   <= 1'b0;
            o_busy      <= 1'b0;
        end else begin
            r_sync1     <= i_rxd;
            r_sync2     <= r_sync1;
            o_frame_err <= 1'b0;
            o_overrun   <= 1'b0;
            if (i_rx_ack)
                o_rx_valid <= 1'b0;
            case (r_state)
                IDLE: begin
                    r_cnt <= '0;
                    if (!w_rs) begin
                        r_state <= START;
                        o_busy  <= 1'b1;
                    end
                end
                START: begin
                    if (w_half_end) begin
                        r_cnt <= '0;
                        r_bit <= '0;
                        // line back high at mid start bit: treat as noise, no flag
                        if (w_rs) begin
                            r_state <= IDLE;
                            o_busy  <= 1'b0;
                        end else begin
                            r_state <= DATA;
                        end
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                DATA: begin
                    if (w_bit_end) begin
                        r_cnt   <= '0;
                        r_shift <= {w_rs, r_shift[7:1]};
                        r_bit   <= r_bit + 3'd1;
                        if (r_bit == 3'd7)
                            r_state <= STOP;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                STOP: begin
                    if (w_bit_end) begin
                        r_cnt <= '0;
                        if (w_rs) begin
                            r_state    <= IDLE;
                            o_busy     <= 1'b0;
                            o_rx_data  <= r_shift;
                            o_rx_valid <= 1'b1;
                            // an ack landing in the load cycle frees the register in time
                            o_overrun  <= o_rx_valid && !i_rx_ack;
                        end else begin
                            r_state     <= WAITHI;
                            o_frame_err <= 1'b1;
                        end
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                WAITHI: begin
                    // hold off until the break ends so a low line is not seen as a start bit
                    if (w_rs) begin
                        r_state <= IDLE;
                        o_busy  <= 1'b0;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    o_busy  <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_uart_rx_controller.sv
// tb_uart_rx_controller: directed frames against a cycle-scheduled receiver model
module tb_uart_rx_controller;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       rxd = 1'b1;
    logic       ack = 1'b0;
    logic [7:0] rx_data;
    logic       rx_valid, frame_err, overrun, busy;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int last_d = 0;
    int valid_rise = -1;
    int ferr_pulses = 0;
    int ovr_pulses = 0;
    logic prev_valid = 1'b0;

    uart_rx_controller #(.SCYCLE(16), .BAUDRATE(1)) dut (
        .i_clk(clk),
        .i_reset(reset),
        .i_rxd(rxd),
        .i_rx_ack(ack),
        .o_rx_data(rx_data),
        .o_rx_valid(rx_valid),
        .o_frame_err(frame_err),
        .o_overrun(overrun),
        .o_busy(busy)
    );

    always #5 clk = ~clk;

    typedef enum int {BUSY_ON, BUSY_OFF, LOAD, FERR} ev_kind_t;
    typedef struct {
        int         at;
        ev_kind_t   kind;
        logic [7:0] d;
    } ev_t;
    ev_t evq[$];

    logic       m_valid = 1'b0, m_ferr = 1'b0, m_ovr = 1'b0, m_busy = 1'b0;
    logic [7:0] m_data = 8'h00;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    function automatic void sched(input int at, input ev_kind_t k, input logic [7:0] d);
        ev_t e;
        e.at = at;
        e.kind = k;
        e.d = d;
        evq.push_back(e);
    endfunction

    // Edge d is the first clock edge that samples the start bit on RXD; two
    // synchronizer stages put the FSM's first view of it at d+2, the start-bit
    // centre at d+10 and the stop-bit centre at d+10+9*16 = d+154.
    task automatic drive(input logic v, input int n);
        repeat (n) begin
            @(negedge clk);
            rxd = v;
        end
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop_val, input int stop_len, input int gap);
        int d;
        @(negedge clk);
        d = cyc + 1;
        last_d = d;
        rxd = 1'b0;
        sched(d + 2, BUSY_ON, 8'h00);
        if (stop_val) begin
            sched(d + 154, LOAD, b);
            sched(d + 154, BUSY_OFF, 8'h00);
        end else begin
            sched(d + 154, FERR, 8'h00);
            sched(d + 144 + stop_len + 2, BUSY_OFF, 8'h00);
        end
        drive(1'b0, 15);
        for (int n = 0; n < 8; n++)
            drive(b[n], 16);
        drive(stop_val, stop_len);
        drive(1'b1, gap);
    endtask

    task automatic pulse_ack();
        @(negedge clk);
        ack = 1'b1;
        @(negedge clk);
        ack = 1'b0;
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
        if (reset) begin
            m_valid = 1'b0;
            m_ferr = 1'b0;
            m_ovr = 1'b0;
            m_busy = 1'b0;
            m_data = 8'h00;
            evq.delete();
        end else begin
            m_ferr = 1'b0;
            m_ovr = 1'b0;
            if (ack)
                m_valid = 1'b0;
            for (int i = 0; i < evq.size();) begin
                if (evq[i].at == cyc) begin
                    case (evq[i].kind)
                        BUSY_ON:  m_busy = 1'b1;
                        BUSY_OFF: m_busy = 1'b0;
                        FERR:     m_ferr = 1'b1;
                        default: begin
                            m_ovr = m_valid;
                            m_valid = 1'b1;
                            m_data = evq[i].d;
                        end
                    endcase
                    evq.delete(i);
                end else begin
                    i++;
                end
            end
        end
        #1;
        check("busy", busy, m_busy);
        check("rx_valid", rx_valid, m_valid);
        check("rx_data", rx_data, m_data);
        check("frame_err", frame_err, m_ferr);
        check("overrun", overrun, m_ovr);
        if (rx_valid && !prev_valid)
            valid_rise = cyc;
        prev_valid = rx_valid;
        ferr_pulses += int'(frame_err);
        ovr_pulses += int'(overrun);
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge clk);
        reset = 1'b0;
        check("reset_data", rx_data, 8'h00);
        check("reset_valid", rx_valid, 1'b0);
        check("reset_busy", busy, 1'b0);
        drive(1'b1, 5);

        send_frame(8'hA5, 1'b1, 16, 10);
        check("a5_data", rx_data, 8'hA5);
        check("a5_valid", rx_valid, 1'b1);
        check("a5_latency", valid_rise - (last_d + 1), 153);
        check("a5_busy_after", busy, 1'b0);
        check("a5_no_ferr", ferr_pulses, 0);
        pulse_ack();
        check("a5_ack_clears", rx_valid, 1'b0);

        @(negedge clk);
        rxd = 1'b0;
        sched(cyc + 3, BUSY_ON, 8'h00);
        sched(cyc + 11, BUSY_OFF, 8'h00);
        drive(1'b0, 3);
        drive(1'b1, 30);
        check("glitch_valid", rx_valid, 1'b0);
        check("glitch_busy", busy, 1'b0);
        check("glitch_no_ferr", ferr_pulses, 0);

        send_frame(8'h3C, 1'b0, 40, 20);
        check("fe_pulses", ferr_pulses, 1);
        check("fe_valid", rx_valid, 1'b0);
        check("fe_data_kept", rx_data, 8'hA5);
        check("fe_busy_after", busy, 1'b0);

        send_frame(8'h11, 1'b1, 16, 10);
        send_frame(8'h22, 1'b1, 16, 10);
        check("ovr_data", rx_data, 8'h22);
        check("ovr_valid", rx_valid, 1'b1);
        check("ovr_pulses", ovr_pulses, 1);
        pulse_ack();
        send_frame(8'h11, 1'b1, 16, 10);
        fork
            send_frame(8'h22, 1'b1, 16, 10);
            begin
                repeat (155) @(negedge clk);
                ack = 1'b1;
                @(negedge clk);
                ack = 1'b0;
            end
        join
        check("ackload_data", rx_data, 8'h22);
        check("ackload_valid", rx_valid, 1'b1);
        check("ackload_no_ovr", ovr_pulses, 1);

        @(negedge clk);
        rxd = 1'b0;
        sched(cyc + 3, BUSY_ON, 8'h00);
        drive(1'b0, 15);
        for (int n = 0; n < 4; n++)
            drive(1'b1, 16);
        drive(1'b1, 8);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("midreset_data", rx_data, 8'h00);
        check("midreset_valid", rx_valid, 1'b0);
        check("midreset_busy", busy, 1'b0);
        drive(1'b1, 20);
        send_frame(8'h5A, 1'b1, 16, 10);
        check("after_reset_data", rx_data, 8'h5A);
        check("after_reset_valid", rx_valid, 1'b1);
        pulse_ack();

        fork
            begin
                send_frame(8'h00, 1'b1, 16, 0);
                send_frame(8'hFF, 1'b1, 16, 10);
            end
            begin
                repeat (165) @(negedge clk);
                check("b2b_first_data", rx_data, 8'h00);
                check("b2b_first_valid", rx_valid, 1'b1);
                ack = 1'b1;
                @(negedge clk);
                ack = 1'b0;
            end
        join
        check("b2b_second_data", rx_data, 8'hFF);
        check("b2b_second_valid", rx_valid, 1'b1);
        check("b2b_no_ovr", ovr_pulses, 1);
        check("b2b_no_ferr", ferr_pulses, 1);

        drive(1'b1, 5);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/uart_rx_controller.md
Name: uart_rx_controller

Overview:
- Receive-side sequencer for the UART module set. Samples the serial line at bit centres using an internal baud counter and an FSM, and assembles 8N1 frames.
- Holds each completed byte in a one-entry output register with a valid/ack handshake.
- Flags framing errors (stop bit low) and overruns (new byte arrives while the previous byte is unacknowledged).

Parameters:
- SCYCLE, 50_000_000, system clock frequency in Hz.
- BAUDRATE, 9600, line rate in baud.
- BDR (localparam) = SCYCLE / BAUDRATE, cycles per bit. HALF = BDR / 2. Counter width = $clog2(BDR + 1).

Ports:
- CLK  in  1  system clock; all logic on rising edge.
- RESET  in  1  synchronous, active-high reset.
- RXD  in  1  asynchronous serial input; idle level 1.
- RX_ACK  in  1  consumer acknowledge; clears RX_VALID.
- RX_DATA  out  8  received byte, LSB = first data bit.
- RX_VALID  out  1  RX_DATA holds an unacknowledged byte.
- FRAME_ERR  out  1  one-cycle pulse: stop bit sampled low.
- OVERRUN  out  1  one-cycle pulse: byte lost to a full output register.
- BUSY  out  1  FSM is not in IDLE.

Behaviour:
- Reset (RESET=1 at a clock edge):
  - FSM=IDLE, baud counter=0, bit index=0, shift register=0.
  - Synchronizer flops=1.
  - RX_DATA=0, RX_VALID=0, FRAME_ERR=0, OVERRUN=0, BUSY=0.
  - Reset mid-frame abandons the frame; no flags are raised.
- Synchronizer: RXD passes through 2 flops. The FSM sees only the synchronized signal RS. All latencies below are counted from RS.
- FSM states: IDLE, START, DATA, STOP, WAITHI.
- IDLE:
  - Counter held at 0.
  - RS=0 → START.
- START:
  - Counter increments each cycle.
  - At counter==HALF-1, sample RS:
    - RS=0 → DATA, counter=0, bit index=0.
    - RS=1 → glitch; return to IDLE with no flag.
- DATA:
  - Counter counts 0..BDR-1 and wraps to 0.
  - At counter==BDR-1, shift RS into the shift register MSB and shift right (LSB-first assembly), then increment the bit index.
  - On the sample with bit index==7 → STOP, counter=0.
- STOP:
  - At counter==BDR-1, sample RS.
  - RS=1, valid frame:
    - Next cycle: RX_DATA=shift register, RX_VALID=1. FSM → IDLE.
    - If RX_VALID was already 1 and RX_ACK=0 in that cycle: RX_DATA is overwritten with the new byte, OVERRUN pulses for 1 cycle, and RX_VALID stays 1.
  - RS=0, framing error:
    - Next cycle: FRAME_ERR pulses for 1 cycle.
    - The byte is discarded; RX_DATA and RX_VALID are unchanged.
    - FSM → WAITHI.
- WAITHI: stay until RS=1 (break condition), then → IDLE.
- Handshake:
  - RX_ACK=1 while RX_VALID=1 → RX_VALID=0 next cycle.
  - RX_ACK while RX_VALID=0 is ignored.
  - Byte load and ACK in the same cycle: the new byte is loaded, RX_VALID stays 1, no OVERRUN.
- Timing:
  - BUSY = (FSM != IDLE), registered alongside the state.
  - Start bit is sampled HALF cycles after the falling edge at RS.
  - Data bit n is sampled HALF + (n+1)·BDR cycles after that edge.
  - Stop bit is sampled HALF + 9·BDR cycles after that edge.
  - RX_VALID rises 1 cycle after the stop sample.
- Back-to-back frames: a new start edge is accepted in the first IDLE cycle after STOP.
- Flags: FRAME_ERR and OVERRUN are never asserted simultaneously.

Test Plan (SCYCLE=16, BAUDRATE=1 → BDR=16, HALF=8):
- Send 0xA5 (8N1, 16 cycles per bit) → RX_DATA=0xA5; RX_VALID rises 8+144+1 cycles after the RS falling edge; FRAME_ERR=0; BUSY=0 afterwards; RX_ACK clears RX_VALID the next cycle.
- RXD low pulse of 4 cycles → FSM returns to IDLE at counter 7; RX_VALID=0, FRAME_ERR=0.
- Send 0x3C with stop bit held low for 40 cycles → FRAME_ERR pulses once; RX_VALID stays 0; BUSY stays 1 until RXD returns high.
- Send 0x11 then 0x22 with no ACK → RX_DATA=0x22, OVERRUN pulses once, RX_VALID=1. Repeat with ACK asserted in the 0x22 load cycle → RX_DATA=0x22, RX_VALID=1, no OVERRUN.
- Assert RESET during DATA bit 4 of 0xFF → all outputs 0 next cycle; a following 0x5A frame is received correctly.
- Send 0x00 then 0xFF back-to-back with no idle gap → both bytes received in order (acked between frames), no flags.
